// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges the ID load-use hold with
// the EX iterative-divide sequence and owns the divider step/done timing.
module pipe_stall_ctrl #(
  parameter int STALL_WD   = 6,
  parameter int DIV_CYCLES = 32,
  parameter int PERF_WD    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_div_start,
  input  logic                flush,
  output logic [STALL_WD-1:0] stall,
  output logic                div_step,
  output logic                div_done,
  output logic                div_busy,
  output logic [PERF_WD-1:0]  stall_cycles
);

  localparam logic [STALL_WD-1:0] NONE   = '0;
  localparam logic [STALL_WD-1:0] ID_REQ = STALL_WD'(6'b000111);
  localparam logic [STALL_WD-1:0] EX_REQ = STALL_WD'(6'b001111);
  localparam logic [5:0]          CNT_LOAD = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic [PERF_WD-1:0] r_stallCycles;
  logic               w_divLaunch;
  logic               w_stalled;

  assign w_divLaunch = (r_state == IDLE) && ex_div_start && !flush;

  // Outputs are gated by rst and flush so an abort never leaks a hold or a step.
  always_comb begin
    stall    = NONE;
    div_step = 1'b0;
    div_done = 1'b0;
    if (!rst && !flush) begin
      case (r_state)
        IDLE: begin
          if (ex_div_start)     stall = EX_REQ;
          else if (stallreq_id) stall = ID_REQ;
        end
        DIV_BUSY: begin
          stall    = EX_REQ;
          div_step = 1'b1;
        end
        DIV_DONE: begin
          div_done = 1'b1;
          if (stallreq_id) stall = ID_REQ;
        end
        default: stall = NONE;
      endcase
    end
  end

  assign div_busy     = (r_state == DIV_BUSY) && !rst;
  assign w_stalled    = (stall != NONE);
  assign stall_cycles = r_stallCycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_divLaunch) begin
            r_state <= DIV_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        DIV_BUSY: begin
          if (r_cnt == 6'd0) r_state <= DIV_DONE;
          else               r_cnt   <= r_cnt - 6'd1;
        end
        // The DONE cycle's ex_div_start is the same instruction, so it is ignored.
        DIV_DONE: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stallCycles <= '0;
    else if (w_stalled && (r_stallCycles != '1))
      r_stallCycles <= r_stallCycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: load-use, single/back-to-back divides,
// flush mid-divide and async reset mid-divide, with hand-computed expectations.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        ex_div_start;
  logic        flush;
  logic [5:0]  stall;
  logic        div_step;
  logic        div_done;
  logic        div_busy;
  logic [31:0] stall_cycles;

  int vectors;
  int miscompares;

  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] ID_REQ = 6'b000111;
  localparam logic [5:0] EX_REQ = 6'b001111;

  pipe_stall_ctrl #(
    .STALL_WD  (6),
    .DIV_CYCLES(32),
    .PERF_WD   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .ex_div_start(ex_div_start),
    .flush       (flush),
    .stall       (stall),
    .div_step    (div_step),
    .div_done    (div_done),
    .div_busy    (div_busy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs mid-cycle, then let combinational outputs settle.
  task automatic applyStimulus(input logic sid, input logic start, input logic fl);
    @(negedge clk);
    stallreq_id  = sid;
    ex_div_start = start;
    flush        = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expStall,
                             input logic expStep, input logic expDone,
                             input logic expBusy);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {stall, div_step, div_done, div_busy};
    exp = {expStall, expStep, expDone, expBusy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed stall/step/done/busy=%b/%b/%b/%b expected=%b/%b/%b/%b",
             tag, stall, div_step, div_done, div_busy, expStall, expStep, expDone, expBusy);
    end
  endtask

  task automatic checkCount(input string tag, input logic [31:0] expCount);
    vectors++;
    assert (stall_cycles === expCount) else begin
      miscompares++;
      $error("[TB] FAIL %s observed stall_cycles=%0d expected=%0d", tag, stall_cycles, expCount);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    stallreq_id  = 1'b1;
    ex_div_start = 1'b1;
    flush        = 1'b0;

    // Reset forces every output low regardless of inputs
    #12;
    checkOutput("reset_outputs", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("reset_count", 32'd0);

    @(negedge clk);
    rst          = 1'b0;
    stallreq_id  = 1'b0;
    ex_div_start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_quiet", NONE, 1'b0, 1'b0, 1'b0);

    // Load-use only: one cycle of ID_REQ
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_hold", ID_REQ, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_release", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("loaduse_count", 32'd1);

    // Single divide, start held until the instruction advances
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("div1_start", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("div1_busy%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("div1_done", NONE, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("div1_after", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("div1_count", 32'd34);

    // Load-use throughout a divide: EX_REQ dominates, DONE shows ID_REQ
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("div2_start_lu", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("div2_busy_lu%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("div2_done_lu", ID_REQ, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("div2_after", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("div2_count", 32'd68);

    // Flush at busy cycle 5 aborts the divide
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("div3_start", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("div3_busy%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("div3_flush", NONE, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("div3_idle", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("div3_count", 32'd73);

    // Flush overrides a start in IDLE
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_flush_start", NONE, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_flush_after", NONE, 1'b0, 1'b0, 1'b0);

    // Fresh full sequence after the flush
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("div4_start", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("div4_busy%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("div4_done", NONE, 1'b0, 1'b1, 1'b0);
    checkCount("div4_count", 32'd106);

    // Back-to-back divides: second start the cycle after the first DONE
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_a_start", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("b2b_a_busy%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_a_done", NONE, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_b_start", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("b2b_b_busy%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_b_done", NONE, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("b2b_after", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("b2b_count", 32'd172);

    // Async reset at busy cycle 10
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("div5_start", EX_REQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("div5_busy%0d", i), EX_REQ, 1'b1, 1'b0, 1'b1);
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midreset_outputs", NONE, 1'b0, 1'b0, 1'b0);
    checkCount("midreset_count", 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    ex_div_start = 1'b0;
    #1;
    checkOutput("postreset_idle", NONE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("postreset_nodone%0d", i), NONE, 1'b0, 1'b0, 1'b0);
    end
    checkCount("postreset_count", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB); replaces the tie-off controller that drives the shared stall bus.
- Merges the ID load-use stall request with an EX multi-cycle divide sequence: it owns the iterative divider's step/done timing and holds the front of the pipeline until the quotient is ready.
- Sits beside the stage modules; its stall bus fans out to every pipeline register.

Parameters:
- STALL_WD, 6, stall bus width: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- DIV_CYCLES, 32, number of divider step cycles per divide (range 1..63).
- PERF_WD, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- stallreq_id  input  1  load-use hazard detected in ID this cycle.
- ex_div_start  input  1  valid DIV/DIVU instruction is in EX this cycle.
- flush  input  1  exception/redirect: abort any divide sequence.
- stall  output  STALL_WD  pipeline hold vector, combinational from state and inputs.
- div_step  output  1  enable one divider iteration this cycle.
- div_done  output  1  one-cycle pulse: quotient/remainder valid for HI/LO write.
- div_busy  output  1  state is DIV_BUSY.
- stall_cycles  output  PERF_WD  count of cycles with stall != 0, saturating.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, cnt=0, stall_cycles=0.
  - stall=0, div_step=0, div_done=0, div_busy=0, all forced regardless of inputs.
- Stall encodings:
  - NONE = 6'b000000.
  - ID_REQ = 6'b000111: hold PC, IF/ID, ID/EX; bubble into EX.
  - EX_REQ = 6'b001111: hold PC, IF/ID, ID/EX, EX/MEM; bubble into MEM.
- FSM states: IDLE, DIV_BUSY, DIV_DONE.
- IDLE:
  - ex_div_start=1 and flush=0: stall=EX_REQ in the same cycle; next state DIV_BUSY; cnt loads DIV_CYCLES-1.
  - Otherwise: stall=ID_REQ if stallreq_id=1, else NONE.
- DIV_BUSY:
  - stall=EX_REQ, div_step=1, div_busy=1; cnt decrements each cycle.
  - When cnt==0: next state DIV_DONE. This gives exactly DIV_CYCLES step cycles.
- DIV_DONE:
  - div_done=1, div_step=0.
  - stall=ID_REQ if stallreq_id=1, else NONE. The EX instruction advances at the end of this cycle.
  - ex_div_start is ignored (it is the same instruction); next state IDLE.
- Latency: divide start to div_done = DIV_CYCLES+1 cycles. EX is held for DIV_CYCLES+1 cycles, counting the start cycle.
- Back-to-back divides: the second DIV enters EX in the cycle after DIV_DONE, so IDLE sees ex_div_start and restarts. There is no idle gap beyond the DONE cycle.
- Priority: EX_REQ dominates ID_REQ; stallreq_id during DIV_BUSY has no additional effect.
- Flush:
  - In any state: next state IDLE, cnt=0; stall=NONE, div_step=0, div_done=0 in the flush cycle.
  - Flush overrides ex_div_start in IDLE.
- stall_cycles increments on each clock edge where stall != 0 and rst=0; it holds at all-ones.
- cnt width = 6 bits. DIV_CYCLES=1 goes IDLE -> DIV_BUSY (1 cycle) -> DIV_DONE.
- No output depends on a combinational loop; stall depends only on state, stallreq_id, ex_div_start, flush and rst.

Test Plan:
- Reset mid-divide: start DIV, assert rst at busy cycle 10 -> stall=0, div_busy=0, stall_cycles=0 immediately (async). After release, state IDLE with no div_done.
- Single DIV, DIV_CYCLES=32, pulse ex_div_start held until advance -> stall=001111 for 33 cycles, div_step high 32 cycles, div_done high exactly once on cycle 34, stall_cycles=33.
- Load-use only: stallreq_id=1 for 1 cycle in IDLE -> stall=000111 that cycle, 000000 next; stall_cycles=1.
- Load-use during divide: stallreq_id=1 throughout DIV_BUSY and DIV_DONE -> stall=001111 in BUSY, 000111 in the DONE cycle, div_done still pulses.
- Flush at busy cycle 5 -> stall=0 and div_step=0 that cycle; IDLE next; no div_done. A new ex_div_start then gives a full 32-step sequence.
- Back-to-back DIVs -> second sequence starts in the cycle after the first div_done; total 66 stalled cycles, two div_done pulses.
